// File: rtl/traffic_scheduler_if.sv
// Control and lane-output bundle for traffic_scheduler; the testbench or upstream
// control drives through master, the scheduler sits on slave.
interface traffic_scheduler_if #(
  parameter int unsigned LANES = 4
);
  logic             start;
  logic             stop;
  logic             freeze;
  logic [LANES-1:0] rand_bits;
  logic [LANES-1:0] lane_tick;
  logic [LANES-1:0] lane_spawn;
  logic [15:0]      spawn_cnt;
  logic             running;

  modport master (
    output start, stop, freeze, rand_bits,
    input  lane_tick, lane_spawn, spawn_cnt, running
  );

  modport slave (
    input  start, stop, freeze, rand_bits,
    output lane_tick, lane_spawn, spawn_cnt, running
  );
endinterface

// File: rtl/traffic_scheduler.sv
// Multi-lane car spawn scheduler: per-lane step dividers plus a round-robin spawn arbiter.
// Optional feature macro TRAFFIC_GAP_EN adds per-lane minimum spawn gap counters.
module traffic_scheduler #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned BASE_PERIOD = 4,
  parameter int unsigned MIN_GAP     = 2
) (
  input logic                clk,
  input logic                reset,
  traffic_scheduler_if.slave bus
);
  localparam int unsigned CNT_W = (BASE_PERIOD * LANES > 1) ? $clog2(BASE_PERIOD * LANES) : 1;
  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FREEZE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             running_q;
  logic [CNT_W-1:0] cnt_q [LANES];
  logic [PTR_W-1:0] ptr_q, ptr_d, idx_c;
  logic [15:0]      spawn_cnt_q;
  logic [LANES-1:0] tick_c, cand_c, grant_c, gap_ok_c;
  logic             grant_any_c;
  logic             clear_c;

  // Leaving RUN through stop, or sitting in IDLE, wipes dividers, gaps and pointer
  assign clear_c = (state_q == S_IDLE) || bus.stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.start)   state_d = S_RUN;
        S_RUN:    if (bus.freeze)  state_d = S_FREEZE;
        S_FREEZE: if (!bus.freeze) state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

`ifdef TRAFFIC_GAP_EN
  localparam int unsigned GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  logic [GAP_W-1:0] gap_q [LANES];

  always_comb begin
    gap_ok_c = '0;
    for (int unsigned i = 0; i < LANES; i++) gap_ok_c[i] = (gap_q[i] == '0);
  end

  // A grant reloads the gap; later non-granted ticks count it down
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LANES; i++) gap_q[i] <= '0;
    end else if (clear_c) begin
      for (int unsigned i = 0; i < LANES; i++) gap_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (grant_c[i])                         gap_q[i] <= GAP_W'(MIN_GAP);
        else if (tick_c[i] && gap_q[i] != '0)   gap_q[i] <= gap_q[i] - GAP_W'(1);
      end
    end
  end
`else
  assign gap_ok_c = '1;
`endif

  // Tick decode, candidacy and round-robin grant starting at ptr_q
  always_comb begin
    tick_c      = '0;
    grant_c     = '0;
    grant_any_c = 1'b0;
    ptr_d       = ptr_q;
    idx_c       = '0;
    for (int unsigned i = 0; i < LANES; i++)
      tick_c[i] = (state_q == S_RUN) && (cnt_q[i] == CNT_W'(BASE_PERIOD * (i + 1) - 1));
    cand_c = tick_c & bus.rand_bits & gap_ok_c;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx_c = PTR_W'(((32'(ptr_q) + k) >= LANES) ? (32'(ptr_q) + k - LANES) : (32'(ptr_q) + k));
      if (!grant_any_c && cand_c[idx_c]) begin
        grant_c[idx_c] = 1'b1;
        grant_any_c    = 1'b1;
        ptr_d          = (32'(idx_c) == LANES - 1) ? '0 : idx_c + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) cnt_q[i] <= '0;
    end else if (clear_c) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (state_q == S_RUN) begin
        for (int unsigned i = 0; i < LANES; i++)
          cnt_q[i] <= tick_c[i] ? '0 : cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Grant tally survives stop; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     spawn_cnt_q <= '0;
    else if (grant_any_c && spawn_cnt_q != 16'hFFFF) spawn_cnt_q <= spawn_cnt_q + 16'd1;
  end

  assign bus.lane_tick  = tick_c;
  assign bus.lane_spawn = grant_c;
  assign bus.spawn_cnt  = spawn_cnt_q;
  assign bus.running    = running_q;
endmodule

// File: doc/traffic_scheduler.md
TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LANES, 4, number of car lanes.
REQ-002 BASE_PERIOD, 4, clk cycles between steps for lane 0; lane i steps every BASE_PERIOD*(i+1) cycles.
REQ-003 MIN_GAP, 2, minimum number of non-spawning steps after a spawn in the same lane.
REQ-004 Port clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  reset, asynchronous and active-low.
REQ-006 Port start  in  1  one-cycle pulse; begins traffic.
REQ-007 Port stop  in  1  one-cycle pulse; ends traffic and clears the scheduler.
REQ-008 Port freeze  in  1  level; holds all traffic while high.
REQ-009 Port rand_bits  in  LANES  per-lane spawn request bits from the LFSR.
REQ-010 Port lane_tick  out  LANES  one-cycle step enable for each lane's LED shift chain.
REQ-011 Port lane_spawn  out  LANES  car injected at each lane's first LED; drives that LED's NL input.
REQ-012 Port spawn_cnt  out  16  total granted spawns.
REQ-013 Port running  out  1  high in RUN state.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and FREEZE.
REQ-015 IDLE->RUN on start; RUN->FREEZE while freeze=1; FREEZE->RUN when freeze=0; any state->IDLE on stop; stop SHALL win over start and freeze.
REQ-016 Per-lane divider cnt_i SHALL count 0..BASE_PERIOD*(i+1)-1 in RUN, wrap to 0, hold in FREEZE and clear to 0 in IDLE.
REQ-017 lane_tick[i] SHALL be 1 in exactly the RUN cycles where cnt_i is at terminal count; it is combinational from state and counter, with zero latency.
REQ-018 Lane i SHALL be a candidate when lane_tick[i]=1, rand_bits[i]=1 and gap_i=0.
REQ-019 A round-robin arbiter SHALL grant at most one candidate per cycle, searching upward from pointer ptr and wrapping at LANES-1.
REQ-020 After a grant to lane g, ptr SHALL become (g+1) mod LANES; ptr SHALL be unchanged when nothing is granted.
REQ-021 lane_spawn SHALL equal the one-hot grant in the same cycle as the tick; ungranted candidates SHALL be dropped, not queued.
REQ-022 On a grant gap_g SHALL load MIN_GAP; on a non-granted lane_tick[i] with gap_i>0, gap_i SHALL decrement by 1; a grant SHALL take priority over the decrement.
REQ-023 spawn_cnt SHALL increment by 1 per grant, saturate at 16'hFFFF, and clear only on reset.
REQ-024 A stop SHALL clear cnt_i, gap_i and ptr on the following edge; lane_tick and lane_spawn SHALL be 0 outside RUN.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, all cnt_i=0, gap_i=0, ptr=0, spawn_cnt=0, lane_tick=0, lane_spawn=0 and running=0, independent of clk.
REQ-026 After reset releases, the block SHALL stay in IDLE until start.

Configuration
REQ-027 With macro TRAFFIC_GAP_EN defined, gap counters SHALL exist and behave per REQ-018 and REQ-022.
REQ-028 Without TRAFFIC_GAP_EN, gap counters SHALL NOT be built, and candidacy SHALL be lane_tick[i] and rand_bits[i] only.

Verification (LANES=4, BASE_PERIOD=4, MIN_GAP=2, TRAFFIC_GAP_EN defined unless stated)
REQ-029 Reset, then start at cycle 0 with rand_bits=0 -> lane_tick[0] at cycles 4, 8, 12; lane_tick[1] at 8, 16; lane_spawn stays 0.
REQ-030 rand_bits=4'b0001 held -> lane 0 spawns at its ticks at cycles 4 and 16 only (8 and 12 blocked); spawn_cnt=2 at cycle 17.
REQ-031 rand_bits=4'b0011 with lanes 0 and 1 ticking together at cycle 8, ptr=0 -> lane_spawn=4'b0001 and ptr becomes 1; the next coincident tick with both lanes eligible grants lane 1.
REQ-032 freeze=1 for 5 cycles mid-run -> no ticks; counters resume from held values; tick schedule shifts by exactly 5 cycles.
REQ-033 reset asserted mid-cycle during RUN -> all outputs 0 before the next clk edge; stop in RUN -> IDLE and counters 0 after one edge.
REQ-034 TRAFFIC_GAP_EN undefined, rand_bits=4'b0001 -> lane 0 spawns on every tick (cycles 4, 8, 12, 16).
